layer3_mac_engine: RTL and testbench

Sequencing multiply-accumulate engine for MLP layer 3, directly downstream of the layer-3 weight ROM. Generates weight and activation addresses, multiplies each 16-bit Q8.8 weight by the matching 16-bit Q8.8 activation, and accumulates one neuron at a time. Emits one saturated Q8.8 result per output neuron over a valid/ready handshake toward the classifier/argmax stage.

---
 rtl/mlp_pkg.sv | 38 +++
 rtl/fxp_mac.sv | 44 ++++
 rtl/layer3_mac_engine.sv | 115 +++++++++++
 tb/tb_layer3_mac_engine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared fixed-point definitions for the MLP layer engines: Q8.8 data,
// 40-bit accumulators, engine state encoding and the output saturation stage.
package mlp_pkg;

    localparam int FRAC_BITS = 8;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 40;
    localparam int WADDR_W   = 14;
    localparam int PROD_W    = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] Q_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] Q_MIN = -40'sd32768;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } mac_state_t;

    // Q16.16 accumulator -> Q8.8: floor shift, clamp, optional ReLU.
    function automatic logic [DATA_W-1:0] sat_q88(input logic signed [ACC_W-1:0] x,
                                                  input logic relu);
        logic signed [ACC_W-1:0] s;
        logic [DATA_W-1:0] r;
        s = x >>> FRAC_BITS;
        if (s > Q_MAX)
            r = 16'h7FFF;
        else if (s < Q_MIN)
            r = 16'h8000;
        else
            r = s[DATA_W-1:0];
        if (relu && r[DATA_W-1])
            r = '0;
        return r;
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Two-stage signed multiply-accumulate: registered Q8.8 x Q8.8 product,
// then a 40-bit accumulator. acc_next exposes the sum including any pending product.
module fxp_mac
    import mlp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              mul_en,
    input  logic              flush,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc_next
);

    logic signed [PROD_W-1:0] p_reg;
    logic                     p_vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  p_ext;
    logic signed [PROD_W-1:0] prod;

    assign prod     = $signed(a) * $signed(b);
    assign p_ext    = {{(ACC_W-PROD_W){p_reg[PROD_W-1]}}, p_reg};
    assign acc_next = acc + (p_vld ? p_ext : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg <= '0;
            p_vld <= 1'b0;
            acc   <= '0;
        end else if (clear) begin
            p_vld <= 1'b0;
            acc   <= '0;
        end else if (mul_en) begin
            p_reg <= prod;
            p_vld <= 1'b1;
            acc   <= acc_next;
        end else if (flush) begin
            p_vld <= 1'b0;
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/layer3_mac_engine.sv
// Layer-3 MLP engine: walks neuron/k over the weight ROM and activation buffer,
// accumulates one neuron at a time and hands each saturated result downstream.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one product per cycle, k = 0..N_IN-1
//   DRAIN | fold in last product, latch saturated result
//   EMIT  | result offered on out_valid until accepted
module layer3_mac_engine
    import mlp_pkg::*;
#(
    parameter int N_IN  = 32,
    parameter int N_OUT = 10,
    parameter int RELU  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [WADDR_W-1:0]       wt_addr,
    input  logic [DATA_W-1:0]        wt_data,
    output logic [$clog2(N_IN)-1:0]  act_addr,
    input  logic [DATA_W-1:0]        act_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_OUT)-1:0] out_idx,
    output logic [DATA_W-1:0]        out_data
);

    localparam int KW = $clog2(N_IN);
    localparam int NW = $clog2(N_OUT);
    localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

    mac_state_t    state;
    logic [NW-1:0] neuron;
    logic [KW-1:0] k;
    logic          mac_clear;
    logic          mac_mul;
    logic          mac_flush;
    logic [ACC_W-1:0] acc_next;

    // Addresses come straight from the counters, so they hold outside RUN.
    assign wt_addr  = WADDR_W'(neuron) * WADDR_W'(N_IN) + WADDR_W'(k);
    assign act_addr = k;
    assign out_idx  = neuron;

    assign mac_mul   = (state == RUN);
    assign mac_flush = (state == DRAIN);
    assign mac_clear = ((state == IDLE) && start && !done) ||
                       ((state == EMIT) && out_ready && (neuron != N_LAST));

    fxp_mac u_mac (
        .clk      (clk),
        .rst      (reset),
        .clear    (mac_clear),
        .mul_en   (mac_mul),
        .flush    (mac_flush),
        .a        (wt_data),
        .b        (act_data),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            neuron    <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start overlapping the done pulse is not taken.
                    if (start && !done) begin
                        state  <= RUN;
                        neuron <= '0;
                        k      <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (k == K_LAST)
                        state <= DRAIN;
                    else
                        k <= k + 1'b1;
                end
                DRAIN: begin
                    out_data  <= sat_q88(acc_next, RELU != 0);
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (neuron == N_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            neuron <= neuron + 1'b1;
                            k      <= '0;
                            state  <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer3_mac_engine.sv
// Directed bench for layer3_mac_engine: two instances (RELU=0 / RELU=1) fed by
// a pattern ROM model, checked with immediate assertions at each step.
module tb_layer3_mac_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready;
    int          mode;

    logic        busy0, done0, v0, busy1, done1, v1;
    logic [13:0] wa0, wa1;
    logic [4:0]  aa0, aa1;
    logic [15:0] wd0, wd1, ad0, ad1, od0, od1;
    logic [3:0]  idx0, idx1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_wt(input int m, input logic [13:0] a);
        logic [15:0] t;
        case (m)
            1: t = 16'h7FFF;
            2: t = 16'h8000;
            3: t = 16'hFF00;
            4: begin t = 16'(a >> 5) + 16'd1; t = t << 8; end
            5: t = {2'b00, a};
            default: t = 16'h0100;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] rom_act(input int m, input logic [4:0] a);
        logic [15:0] t;
        case (m)
            1, 2: t = 16'h7FFF;
            5: t = (a == 5'd5) ? 16'h0100 : 16'h0000;
            default: t = 16'h0100;
        endcase
        return t;
    endfunction

    // Hand-derived per-neuron results for each pattern (N_IN = 32).
    function automatic logic [15:0] exp_out(input int m, input int n, input bit relu);
        logic [15:0] e;
        case (m)
            0: e = 16'h2000;
            1: e = 16'h7FFF;
            2: e = 16'h8000;
            3: e = 16'hE000;
            4: e = (n < 3) ? 16'((n + 1) * 8192) : 16'h7FFF;
            5: e = 16'(n * 32 + 5);
            default: e = 16'h0000;
        endcase
        if (relu && e[15]) e = 16'h0000;
        return e;
    endfunction

    assign wd0 = rom_wt(mode, wa0);
    assign ad0 = rom_act(mode, aa0);
    assign wd1 = rom_wt(mode, wa1);
    assign ad1 = rom_act(mode, aa1);

    layer3_mac_engine #(.N_IN(32), .N_OUT(10), .RELU(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
        .wt_addr(wa0), .wt_data(wd0), .act_addr(aa0), .act_data(ad0),
        .out_valid(v0), .out_ready(out_ready), .out_idx(idx0), .out_data(od0));

    layer3_mac_engine #(.N_IN(32), .N_OUT(10), .RELU(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
        .wt_addr(wa1), .wt_data(wd1), .act_addr(aa1), .act_data(ad1),
        .out_valid(v1), .out_ready(out_ready), .out_idx(idx1), .out_data(od1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_valid"}, v0, 0);
        chk({tag, "_data"}, od0, 0);
        chk({tag, "_idx"}, idx0, 0);
        chk({tag, "_wt_addr"}, wa0, 0);
        chk({tag, "_act_addr"}, aa0, 0);
        chk({tag, "_busy_r1"}, busy1, 0);
    endtask

    // One full layer pass; el counts rising edges after the start-sampling edge.
    task automatic run_layer(input int stall_n, input bit spam);
        int el;
        int guard;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        el = 0;
        chk($sformatf("m%0d_busy_start", mode), busy0, 1);
        chk($sformatf("m%0d_wt_addr_start", mode), wa0, 0);
        for (int n = 0; n < 10; n++) begin
            if (spam && n == 2) begin
                start = 1'b1;
                @(negedge clk);
                el++;
                start = 1'b0;
            end
            guard = 0;
            while (!v0 && guard < 200) begin
                @(negedge clk);
                el++;
                guard++;
            end
            chk($sformatf("m%0d_n%0d_valid", mode, n), v0, 1);
            chk($sformatf("m%0d_n%0d_valid_r1", mode, n), v1, 1);
            if (stall_n < 0)
                chk($sformatf("m%0d_n%0d_valid_time", mode, n), el, 34 * n + 33);
            chk($sformatf("m%0d_n%0d_idx", mode, n), idx0, n);
            chk($sformatf("m%0d_n%0d_data", mode, n), od0, exp_out(mode, n, 1'b0));
            chk($sformatf("m%0d_n%0d_idx_r1", mode, n), idx1, n);
            chk($sformatf("m%0d_n%0d_data_r1", mode, n), od1, exp_out(mode, n, 1'b1));
            if (n == stall_n) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    el++;
                    chk("stall_valid", v0, 1);
                    chk("stall_data", od0, exp_out(mode, n, 1'b0));
                    chk("stall_idx", idx0, n);
                    chk("stall_wt_addr", wa0, n * 32 + 31);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            el++;
            chk($sformatf("m%0d_n%0d_valid_drop", mode, n), v0, 0);
            if (n < 9) begin
                chk($sformatf("m%0d_n%0d_busy", mode, n), busy0, 1);
                chk($sformatf("m%0d_n%0d_next_wt_addr", mode, n), wa0, (n + 1) * 32);
                chk($sformatf("m%0d_n%0d_next_act_addr", mode, n), aa0, 0);
                chk($sformatf("m%0d_n%0d_no_done", mode, n), done0, 0);
            end else begin
                chk($sformatf("m%0d_done", mode), done0, 1);
                chk($sformatf("m%0d_done_r1", mode), done1, 1);
                chk($sformatf("m%0d_busy_at_done", mode), busy0, 0);
                if (stall_n < 0)
                    chk($sformatf("m%0d_done_time", mode), el, 340);
                @(negedge clk);
                chk($sformatf("m%0d_done_pulse", mode), done0, 0);
                chk($sformatf("m%0d_idle_busy", mode), busy0, 0);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        mode      = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        mode = 0; run_layer(-1, 1'b0);
        mode = 1; run_layer(-1, 1'b0);
        mode = 2; run_layer(-1, 1'b0);
        mode = 3; run_layer(-1, 1'b0);
        mode = 4; run_layer(-1, 1'b1);
        mode = 5; run_layer(3, 1'b0);

        // Abort during neuron 5, then a clean pass.
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5 * 34 + 10) @(negedge clk);
        chk("mid_busy", busy0, 1);
        chk("mid_wt_addr", wa0, 5 * 32 + 10);
        chk("mid_act_addr", aa0, 10);
        reset = 1'b1;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done0, 0);
            chk("abort_idle", busy0, 0);
        end
        run_layer(-1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
